clk_div_gen: RTL



---
 rtl/clk_div_gen_if.sv | 24 ++
 rtl/clk_div_gen.sv | 109 ++++++++++
 2 files changed

// File: rtl/clk_div_gen_if.sv
// Control and status bundle for clk_div_gen: the run request and half-period go in,
// the divided clock, its edge strobes, the activity flag and the rise counter come out.
interface clk_div_gen_if #(
  parameter int CNT_W      = 8,
  parameter int EDGE_CNT_W = 16
);
  logic                  en;
  logic [CNT_W-1:0]      half_period;
  logic                  div_clk;
  logic                  rise_stb;
  logic                  fall_stb;
  logic                  active;
  logic [EDGE_CNT_W-1:0] rise_count;

  modport master (
    output en, half_period,
    input  div_clk, rise_stb, fall_stb, active, rise_count
  );

  modport slave (
    input  en, half_period,
    output div_clk, rise_stb, fall_stb, active, rise_count
  );
endinterface

// File: rtl/clk_div_gen.sv
// Glitch-free programmable clock divider: registered div_clk plus single-cycle rise/fall
// strobes for clk-domain consumers, with a wrapping count of rising edges.
module clk_div_gen #(
  parameter int CNT_W      = 8,
  parameter int EDGE_CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  clk_div_gen_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_e;

  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [EDGE_CNT_W-1:0] EDGE_ONE = EDGE_CNT_W'(1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      hp_q, hp_d;
  logic                  div_clk_q, div_clk_d;
  logic                  rise_stb_q, rise_stb_d;
  logic                  fall_stb_q, fall_stb_d;
  logic [EDGE_CNT_W-1:0] rise_count_q, rise_count_d;
  logic [CNT_W-1:0]      hp_eff;

  assign hp_eff = (bus.half_period == '0) ? CNT_ONE : bus.half_period;

  // The half-period is only re-latched when a low phase starts, keeping each period symmetric.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hp_d         = hp_q;
    div_clk_d    = div_clk_q;
    rise_stb_d   = 1'b0;
    fall_stb_d   = 1'b0;
    rise_count_d = rise_count_q;

    unique case (state_q)
      IDLE: begin
        div_clk_d = 1'b0;
        if (bus.en) begin
          hp_d    = hp_eff;
          cnt_d   = hp_eff - CNT_ONE;
          state_d = LOW;
        end
      end
      LOW: begin
        if (!bus.en) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          div_clk_d    = 1'b1;
          rise_stb_d   = 1'b1;
          rise_count_d = rise_count_q + EDGE_ONE;
          cnt_d        = hp_q - CNT_ONE;
          state_d      = HIGH;
        end
      end
      HIGH: begin
        // A high phase always runs to completion; en only matters at its end.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          div_clk_d  = 1'b0;
          fall_stb_d = 1'b1;
          if (bus.en) begin
            hp_d    = hp_eff;
            cnt_d   = hp_eff - CNT_ONE;
            state_d = LOW;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        div_clk_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hp_q         <= CNT_ONE;
      div_clk_q    <= 1'b0;
      rise_stb_q   <= 1'b0;
      fall_stb_q   <= 1'b0;
      rise_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hp_q         <= hp_d;
      div_clk_q    <= div_clk_d;
      rise_stb_q   <= rise_stb_d;
      fall_stb_q   <= fall_stb_d;
      rise_count_q <= rise_count_d;
    end
  end

  assign bus.div_clk    = div_clk_q;
  assign bus.rise_stb   = rise_stb_q;
  assign bus.fall_stb   = fall_stb_q;
  assign bus.active     = (state_q != IDLE);
  assign bus.rise_count = rise_count_q;

endmodule
